// File: rtl/serial_rx_pkg.sv
// Shared types and frame constants for the serial keystroke receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer preset to the idle-high level, with a falling-edge pulse
// derived from the synchronized output.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_fall = r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/serial_frame_rx.sv
// Two-wire serial frame receiver with valid/ready byte output.
// Optional odd-parity frame format enabled by defining TAPPY_RX_PARITY_EN.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TW             = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_clk,
  input  logic                 ser_dat,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 timeout
);

  logic w_clk_fall, w_clk_s, w_dat_s, w_dat_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ser_clk),
    .o_q    (w_clk_s),
    .o_fall (w_clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ser_dat),
    .o_q    (w_dat_s),
    .o_fall (w_dat_fall_unused)
  );

  state_e               r_state, w_state_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic [2:0]           r_bitcnt, w_bitcnt_d;
  logic [TW-1:0]        r_tcnt, w_tcnt_d;
  logic                 r_fall, r_bit;
  logic [DATA_BITS-1:0] r_data, w_data_d;
  logic                 r_valid, w_valid_d;
  logic                 r_ferr, w_ferr_d;
  logic                 r_ovr, w_ovr_d;
  logic                 r_tout, w_tout_d;
  logic                 w_good, w_drain;
`ifdef TAPPY_RX_PARITY_EN
  logic                 r_par_ok, w_par_ok_d;
`endif

  assign w_drain = r_valid & out_ready;

  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_bitcnt_d = r_bitcnt;
    w_tcnt_d   = r_tcnt;
    w_ferr_d   = 1'b0;
    w_tout_d   = 1'b0;
    w_good     = 1'b0;
`ifdef TAPPY_RX_PARITY_EN
    w_par_ok_d = r_par_ok;
`endif

    // Saturating inter-edge counter; any edge restarts the window.
    if (r_fall) begin
      w_tcnt_d = '0;
    end else if (r_state != IDLE && r_tcnt != TW'(TIMEOUT_CYCLES)) begin
      w_tcnt_d = r_tcnt + TW'(1);
    end

    if (r_fall) begin
      unique case (r_state)
        IDLE: begin
          if (r_bit == START_BIT) begin
            w_state_d  = DATA;
            w_bitcnt_d = '0;
          end else begin
            w_ferr_d = 1'b1;
          end
        end
        DATA: begin
          w_shift_d  = {r_bit, r_shift[DATA_BITS-1:1]};
          w_bitcnt_d = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'(DATA_BITS - 1)) begin
`ifdef TAPPY_RX_PARITY_EN
            w_state_d = PARITY;
`else
            w_state_d = STOP;
`endif
          end
        end
`ifdef TAPPY_RX_PARITY_EN
        PARITY: begin
          w_par_ok_d = (^r_shift) ^ r_bit;
          w_state_d  = STOP;
        end
`endif
        STOP: begin
          w_state_d = IDLE;
`ifdef TAPPY_RX_PARITY_EN
          if (r_bit == STOP_BIT && r_par_ok) w_good = 1'b1;
`else
          if (r_bit == STOP_BIT) w_good = 1'b1;
`endif
          else w_ferr_d = 1'b1;
        end
        default: w_state_d = IDLE;
      endcase
    end else if (r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_tout_d  = 1'b1;
      w_state_d = IDLE;
    end
  end

  // Holding register: a drain in the same cycle frees the slot for a new byte.
  always_comb begin
    w_data_d  = r_data;
    w_valid_d = r_valid & ~w_drain;
    w_ovr_d   = 1'b0;
    if (w_good) begin
      if (!r_valid || w_drain) begin
        w_data_d  = r_shift;
        w_valid_d = 1'b1;
      end else begin
        w_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tcnt   <= '0;
      r_fall   <= 1'b0;
      r_bit    <= 1'b1;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_tout   <= 1'b0;
`ifdef TAPPY_RX_PARITY_EN
      r_par_ok <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_bitcnt <= w_bitcnt_d;
      r_tcnt   <= w_tcnt_d;
      r_fall   <= w_clk_fall;
      r_bit    <= w_dat_s;
      r_data   <= w_data_d;
      r_valid  <= w_valid_d;
      r_ferr   <= w_ferr_d;
      r_ovr    <= w_ovr_d;
      r_tout   <= w_tout_d;
`ifdef TAPPY_RX_PARITY_EN
      r_par_ok <= w_par_ok_d;
`endif
    end
  end

  logic w_clk_s_unused;
  assign w_clk_s_unused = w_clk_s;

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign timeout   = r_tout;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx; define TAPPY_RX_PARITY_EN to exercise the parity frame.
`timescale 1ns/1ps
module tb_serial_frame_rx;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned TIMEOUT_CYCLES = 1000;
  localparam int unsigned TW             = 10;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ser_clk   = 1'b1;
  logic       ser_dat   = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_ferr = 0, cnt_ovr = 0, cnt_tout = 0;
  logic [7:0] got[$];

  always #500 clk = ~clk;

  serial_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_clk   (ser_clk),
    .ser_dat   (ser_dat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always @(negedge clk) begin
    if (frame_err) cnt_ferr++;
    if (overrun)   cnt_ovr++;
    if (timeout)   cnt_tout++;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 16-cycle bit period; data changes mid-way through the high phase.
  task automatic send_bit(input logic b);
    ser_dat = b;
    tick(4);
    ser_clk = 1'b0;
    tick(8);
    ser_clk = 1'b1;
    tick(4);
  endtask

  task automatic send_head(input logic [7:0] d, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TAPPY_RX_PARITY_EN
    send_bit(~(^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 10-bit build");
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_head(d, 1'b0);
    send_bit(stop);
    ser_dat = 1'b1;
  endtask

  initial begin
    #(100_000 * 1000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, t0, lat, first;

    // Reset state
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  8'h00);
    check("rst_ferr",  frame_err, 0);
    check("rst_ovr",   overrun,   0);
    check("rst_tout",  timeout,   0);
    rst_n = 1'b1;
    tick(3);

    // Sequence 0x00..0x0F with out_ready held high
    got.delete();
    f0 = cnt_ferr; o0 = cnt_ovr; t0 = cnt_tout;
    for (int d = 0; d < 16; d++) begin
      send_frame(8'(d), 1'b1);
      tick(2);
    end
    check("seq_count", got.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("seq_byte%0d", i), got[i], i);
    check("seq_ferr", cnt_ferr - f0, 0);
    check("seq_ovr",  cnt_ovr - o0,  0);
    check("seq_tout", cnt_tout - t0, 0);

    // Latency from stop-bit pin fall to out_valid
    got.delete();
    send_head(8'hA5, 1'b0);
    ser_dat = 1'b1;
    tick(4);
    ser_clk = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("lat_cycles", lat, SYNC_STAGES + 2);
    check("lat_data", out_data, 8'hA5);
    tick(8);
    ser_clk = 1'b1;
    tick(4);

    // Overrun with the holding register full
    got.delete();
    out_ready = 1'b0;
    o0 = cnt_ovr; f0 = cnt_ferr;
    send_frame(8'h3C, 1'b1);
    tick(2);
    send_frame(8'h5A, 1'b1);
    tick(2);
    check("ovr_pulses", cnt_ovr - o0, 1);
    check("ovr_valid",  out_valid, 1);
    check("ovr_hold",   out_data,  8'h3C);
    check("ovr_none_taken", got.size(), 0);
    out_ready = 1'b1;
    tick(1);
    check("ovr_drop_valid", out_valid, 0);
    check("ovr_taken_cnt", got.size(), 1);
    check("ovr_taken_byte", got[0], 8'h3C);
    check("ovr_ferr", cnt_ferr - f0, 0);

    // Bad stop bit then recovery
    got.delete();
    f0 = cnt_ferr;
    send_frame(8'h81, 1'b0);
    tick(2);
    check("stop_ferr", cnt_ferr - f0, 1);
    check("stop_nobyte", got.size(), 0);
    check("stop_valid", out_valid, 0);
    send_frame(8'h42, 1'b1);
    tick(2);
    check("stop_next_cnt", got.size(), 1);
    check("stop_next_byte", got[0], 8'h42);

    // Line clock stalls after 4 data bits
    got.delete();
    t0 = cnt_tout; f0 = cnt_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ser_dat = 1'b1;
    tick(4);
    ser_clk = 1'b0;
    first = 0;
    for (int n = 1; n <= 1300; n++) begin
      tick(1);
      if (n == 8) ser_clk = 1'b1;
      if (timeout && first == 0) first = n;
    end
    check("tout_when", first, TIMEOUT_CYCLES + SYNC_STAGES + 2);
    check("tout_pulses", cnt_tout - t0, 1);
    check("tout_ferr", cnt_ferr - f0, 0);
    check("tout_nobyte", got.size(), 0);
    send_frame(8'h7E, 1'b1);
    tick(2);
    check("tout_next_cnt", got.size(), 1);
    check("tout_next_byte", got[0], 8'h7E);

`ifdef TAPPY_RX_PARITY_EN
    // Odd parity: good then corrupted
    got.delete();
    f0 = cnt_ferr;
    send_head(8'h01, 1'b0);
    send_bit(1'b1);
    tick(2);
    check("par_ok_cnt", got.size(), 1);
    check("par_ok_byte", got[0], 8'h01);
    check("par_ok_ferr", cnt_ferr - f0, 0);
    got.delete();
    send_head(8'h01, 1'b1);
    send_bit(1'b1);
    tick(2);
    check("par_bad_ferr", cnt_ferr - f0, 1);
    check("par_bad_nobyte", got.size(), 0);
    check("par_bad_valid", out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
